// File: rtl/fetch_stage.sv
// IF stage: PC register plus IF/ID register. Redirect (branch/jump) wins over stall and flushes IF/ID; one-cycle PC update latency.
// Backpressure: stall holds both PC and IF/ID. Every output is a flop, so no input reaches an output combinationally.
module fetch_stage #(
  parameter int              size     = 32,
  parameter logic [size-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [size-1:0] pc,
  input  logic [size-1:0] pc_plus_4,
  input  logic [31:0]     instr,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [size-1:0] branch_target,
  input  logic            jump,
  input  logic [size-1:0] jump_target,
  output logic [size-1:0] ifid_pc_plus_4,
  output logic [31:0]     ifid_instr,
  output logic            ifid_valid,
  output logic [31:0]     fetch_count
);

  localparam logic [size-1:0] ALIGN = {{(size-2){1'b1}}, 2'b00};

  logic            redirect;
  logic            load;
  logic [size-1:0] next_pc;

  assign redirect = branch_taken | jump;
  assign load     = ~redirect & ~stall;

  // Branch beats jump beats stall beats sequential; every PC source is word-aligned.
  always_comb begin
    next_pc = pc;
    if (branch_taken)
      next_pc = branch_target & ALIGN;
    else if (jump)
      next_pc = jump_target & ALIGN;
    else if (!stall)
      next_pc = pc_plus_4 & ALIGN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC & ALIGN;
    else
      pc <= next_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_pc_plus_4 <= '0;
      ifid_instr     <= '0;
      ifid_valid     <= 1'b0;
      fetch_count    <= '0;
    end else if (redirect) begin
      ifid_pc_plus_4 <= '0;
      ifid_instr     <= '0;
      ifid_valid     <= 1'b0;
    end else if (load) begin
      ifid_pc_plus_4 <= pc_plus_4;
      ifid_instr     <= instr;
      ifid_valid     <= 1'b1;
      fetch_count    <= fetch_count + 32'd1;
    end
  end

endmodule
